// File: rtl/simd_ctrl_seq.sv
// rtl/simd_ctrl_seq.sv - SIMD array control sequencer (optional watchdog: SIMD_CTRL_WDOG_EN)
module simd_ctrl_seq #(
  parameter int NUM_PE  = 4,
  parameter int ADDR_W  = 17,
  parameter int INSTR_W = 32,
  parameter int DIMEN_W = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               START_SIGNAL,
  output logic               PC_INCR,
  output logic               INSTR_DONE,
  output logic [NUM_PE-1:0]  WRITE_MAT,
  output logic               MAT_SEL_B,
  output logic [NUM_PE-1:0]  MAC_CTRL,
  output logic [NUM_PE-1:0]  RST_ACC,
  output logic [NUM_PE-1:0]  RST_PC,
  output logic [NUM_PE-1:0]  RST_ADD,
  output logic [NUM_PE-1:0]  OUT_READY,
  input  logic               MAC_DONE,
  output logic [DIMEN_W-1:0] DIMEN,
  output logic               ADDR_START,
  output logic               ADDR_RST,
  output logic [ADDR_W-1:0]  ADDRESS,
  input  logic               FETCH_DONE,
  output logic               WRADDR_START,
  input  logic               STORE_DONE,
  output logic               STOP_SIGNAL,
  output logic               ERR_SIGNAL,
  output logic [1:0]         ERR_CODE
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOADA, S_LOADB, S_MULTACC, S_STORE, S_STOP, S_ERROR
  } state_e;

  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_MASK    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_e              state_q, state_d;
  logic [NUM_PE-1:0]   mask_q, mask_d;
  logic                pc_incr_q, pc_incr_d;
  logic [NUM_PE-1:0]   write_mat_q, write_mat_d;
  logic                mat_sel_b_q, mat_sel_b_d;
  logic [NUM_PE-1:0]   mac_ctrl_q, mac_ctrl_d;
  logic [NUM_PE-1:0]   rst_acc_q, rst_acc_d;
  logic [NUM_PE-1:0]   rst_pc_q, rst_pc_d;
  logic [NUM_PE-1:0]   rst_add_q, rst_add_d;
  logic [NUM_PE-1:0]   out_ready_q, out_ready_d;
  logic [DIMEN_W-1:0]  dimen_q, dimen_d;
  logic                addr_start_q, addr_start_d;
  logic                addr_rst_q, addr_rst_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                wraddr_start_q, wraddr_start_d;
  logic                stop_q, stop_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  // Instruction fields
  logic [2:0]          op_f;
  logic [1:0]          dim_f;
  logic                aclr_f;
  logic [7:0]          mask_f;
  logic [ADDR_W-1:0]   addr_f;
  logic [NUM_PE-1:0]   lane_mask;
  logic                mask_over;
  logic                mask_bad;
  logic                unused_bits;

  assign op_f      = INSTR[2:0];
  assign dim_f     = INSTR[4:3];
  assign aclr_f    = INSTR[5];
  assign mask_f    = INSTR[13:6];
  assign addr_f    = INSTR[INSTR_W-1 -: ADDR_W];
  assign lane_mask = mask_f[NUM_PE-1:0];
  // Mask bits naming lanes that do not exist make the instruction illegal
  assign mask_over = (NUM_PE < 8) ? |(mask_f >> NUM_PE) : 1'b0;
  assign mask_bad  = (lane_mask == '0) || mask_over;
  assign unused_bits = ^INSTR[INSTR_W-ADDR_W-1:14];

`ifdef SIMD_CTRL_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        busy;
  logic        done_here;
  assign busy = (state_q == S_LOADA) || (state_q == S_LOADB) ||
                (state_q == S_MULTACC) || (state_q == S_STORE);
  assign done_here = ((state_q == S_LOADA || state_q == S_LOADB) && FETCH_DONE) ||
                     ((state_q == S_MULTACC) && MAC_DONE) ||
                     ((state_q == S_STORE) && STORE_DONE);
`endif

  // Next-state and next-output decode; outputs land in the register with the state
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    pc_incr_d      = 1'b0;
    write_mat_d    = '0;
    mat_sel_b_d    = 1'b0;
    mac_ctrl_d     = '0;
    rst_acc_d      = '0;
    rst_pc_d       = '0;
    rst_add_d      = '0;
    out_ready_d    = '0;
    dimen_d        = dimen_q;
    addr_start_d   = 1'b0;
    addr_rst_d     = 1'b0;
    address_d      = address_q;
    wraddr_start_d = 1'b0;
    stop_d         = stop_q;
    err_d          = err_q;
    err_code_d     = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (START_SIGNAL) begin
          state_d   = S_FETCH;
          pc_incr_d = 1'b1;
        end
      end

      S_FETCH: begin
        dimen_d   = DIMEN_W'(dim_f);
        mask_d    = lane_mask;
        rst_acc_d = aclr_f ? lane_mask : '0;
        if (op_f == 3'd7) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          stop_d     = 1'b1;
          err_code_d = ERR_OPCODE;
          rst_acc_d  = '0;
        end else if ((op_f >= 3'd2) && (op_f <= 3'd5) && mask_bad) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          stop_d     = 1'b1;
          err_code_d = ERR_MASK;
          rst_acc_d  = '0;
        end else begin
          case (op_f)
            3'd0: state_d = S_IDLE;
            3'd1: begin
              state_d   = S_FETCH;
              pc_incr_d = 1'b1;
            end
            3'd2, 3'd3: begin
              state_d      = (op_f == 3'd3) ? S_LOADB : S_LOADA;
              write_mat_d  = lane_mask;
              mat_sel_b_d  = (op_f == 3'd3);
              address_d    = addr_f;
              addr_start_d = 1'b1;
            end
            3'd4: begin
              state_d    = S_MULTACC;
              mac_ctrl_d = lane_mask;
            end
            3'd5: begin
              state_d        = S_STORE;
              out_ready_d    = lane_mask;
              wraddr_start_d = 1'b1;
              address_d      = addr_f;
              addr_start_d   = 1'b1;
            end
            3'd6: begin
              state_d = S_STOP;
              stop_d  = 1'b1;
            end
            default: state_d = S_ERROR;
          endcase
        end
      end

      S_LOADA, S_LOADB: begin
        if (FETCH_DONE) begin
          state_d    = S_FETCH;
          pc_incr_d  = 1'b1;
          addr_rst_d = 1'b1;
          rst_add_d  = mask_q;
        end else begin
          write_mat_d  = mask_q;
          mat_sel_b_d  = (state_q == S_LOADB);
          addr_start_d = 1'b1;
        end
      end

      S_MULTACC: begin
        if (MAC_DONE) begin
          state_d   = S_FETCH;
          pc_incr_d = 1'b1;
          rst_pc_d  = mask_q;
        end else begin
          mac_ctrl_d = mask_q;
        end
      end

      S_STORE: begin
        if (STORE_DONE) begin
          state_d    = S_FETCH;
          pc_incr_d  = 1'b1;
          addr_rst_d = 1'b1;
        end else begin
          out_ready_d    = mask_q;
          wraddr_start_d = 1'b1;
          addr_start_d   = 1'b1;
        end
      end

      default: begin
        // STOP and ERROR are terminal; flags hold via defaults
      end
    endcase

`ifdef SIMD_CTRL_WDOG_EN
    // Timeout overrides a stalled busy state unless its done arrives this cycle
    if (busy && !done_here && (wdog_q == 16'hFFFE)) begin
      state_d        = S_ERROR;
      write_mat_d    = '0;
      mat_sel_b_d    = 1'b0;
      mac_ctrl_d     = '0;
      out_ready_d    = '0;
      addr_start_d   = 1'b0;
      wraddr_start_d = 1'b0;
      addr_rst_d     = 1'b1;
      err_d          = 1'b1;
      stop_d         = 1'b1;
      err_code_d     = ERR_TIMEOUT;
    end
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (busy) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = wdog_q;
    end
`endif
  end

  // State and registered outputs with asynchronous clear
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q        <= S_IDLE;
      mask_q         <= '0;
      pc_incr_q      <= 1'b0;
      write_mat_q    <= '0;
      mat_sel_b_q    <= 1'b0;
      mac_ctrl_q     <= '0;
      rst_acc_q      <= '1;
      rst_pc_q       <= '1;
      rst_add_q      <= '1;
      out_ready_q    <= '0;
      dimen_q        <= '0;
      addr_start_q   <= 1'b0;
      addr_rst_q     <= 1'b1;
      address_q      <= '0;
      wraddr_start_q <= 1'b0;
      stop_q         <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      pc_incr_q      <= pc_incr_d;
      write_mat_q    <= write_mat_d;
      mat_sel_b_q    <= mat_sel_b_d;
      mac_ctrl_q     <= mac_ctrl_d;
      rst_acc_q      <= rst_acc_d;
      rst_pc_q       <= rst_pc_d;
      rst_add_q      <= rst_add_d;
      out_ready_q    <= out_ready_d;
      dimen_q        <= dimen_d;
      addr_start_q   <= addr_start_d;
      addr_rst_q     <= addr_rst_d;
      address_q      <= address_d;
      wraddr_start_q <= wraddr_start_d;
      stop_q         <= stop_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

`ifdef SIMD_CTRL_WDOG_EN
  // Watchdog counter for stalled load/MAC/store phases
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign INSTR_DONE   = ((state_q == S_IDLE) && START_SIGNAL) | FETCH_DONE | MAC_DONE | STORE_DONE;
  assign PC_INCR      = pc_incr_q;
  assign WRITE_MAT    = write_mat_q;
  assign MAT_SEL_B    = mat_sel_b_q;
  assign MAC_CTRL     = mac_ctrl_q;
  assign RST_ACC      = rst_acc_q;
  assign RST_PC       = rst_pc_q;
  assign RST_ADD      = rst_add_q;
  assign OUT_READY    = out_ready_q;
  assign DIMEN        = dimen_q;
  assign ADDR_START   = addr_start_q;
  assign ADDR_RST     = addr_rst_q;
  assign ADDRESS      = address_q;
  assign WRADDR_START = wraddr_start_q;
  assign STOP_SIGNAL  = stop_q;
  assign ERR_SIGNAL   = err_q;
  assign ERR_CODE     = err_code_q;

endmodule

// File: tb/tb_simd_ctrl_seq.sv
// tb/tb_simd_ctrl_seq.sv - directed bench for simd_ctrl_seq (4-lane and 8-lane instances)
module tb_simd_ctrl_seq;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] INSTR;
  logic        START_SIGNAL, MAC_DONE, FETCH_DONE, STORE_DONE;

  logic        a_pc_incr, a_instr_done, a_mat_sel_b, a_addr_start, a_addr_rst;
  logic        a_wraddr_start, a_stop, a_err;
  logic [3:0]  a_write_mat, a_mac_ctrl, a_rst_acc, a_rst_pc, a_rst_add, a_out_ready;
  logic [1:0]  a_dimen, a_err_code;
  logic [16:0] a_address;

  logic        b_pc_incr, b_instr_done, b_mat_sel_b, b_addr_start, b_addr_rst;
  logic        b_wraddr_start, b_stop, b_err;
  logic [7:0]  b_write_mat, b_mac_ctrl, b_rst_acc, b_rst_pc, b_rst_add, b_out_ready;
  logic [1:0]  b_dimen, b_err_code;
  logic [16:0] b_address;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  always #5 CLK = ~CLK;

  simd_ctrl_seq #(.NUM_PE(4), .ADDR_W(17), .INSTR_W(32), .DIMEN_W(2)) u_dut4 (
    .CLK(CLK), .RSTN(RSTN), .INSTR(INSTR), .START_SIGNAL(START_SIGNAL),
    .PC_INCR(a_pc_incr), .INSTR_DONE(a_instr_done), .WRITE_MAT(a_write_mat),
    .MAT_SEL_B(a_mat_sel_b), .MAC_CTRL(a_mac_ctrl), .RST_ACC(a_rst_acc),
    .RST_PC(a_rst_pc), .RST_ADD(a_rst_add), .OUT_READY(a_out_ready),
    .MAC_DONE(MAC_DONE), .DIMEN(a_dimen), .ADDR_START(a_addr_start),
    .ADDR_RST(a_addr_rst), .ADDRESS(a_address), .FETCH_DONE(FETCH_DONE),
    .WRADDR_START(a_wraddr_start), .STORE_DONE(STORE_DONE),
    .STOP_SIGNAL(a_stop), .ERR_SIGNAL(a_err), .ERR_CODE(a_err_code)
  );

  simd_ctrl_seq #(.NUM_PE(8), .ADDR_W(17), .INSTR_W(32), .DIMEN_W(2)) u_dut8 (
    .CLK(CLK), .RSTN(RSTN), .INSTR(INSTR), .START_SIGNAL(START_SIGNAL),
    .PC_INCR(b_pc_incr), .INSTR_DONE(b_instr_done), .WRITE_MAT(b_write_mat),
    .MAT_SEL_B(b_mat_sel_b), .MAC_CTRL(b_mac_ctrl), .RST_ACC(b_rst_acc),
    .RST_PC(b_rst_pc), .RST_ADD(b_rst_add), .OUT_READY(b_out_ready),
    .MAC_DONE(MAC_DONE), .DIMEN(b_dimen), .ADDR_START(b_addr_start),
    .ADDR_RST(b_addr_rst), .ADDRESS(b_address), .FETCH_DONE(FETCH_DONE),
    .WRADDR_START(b_wraddr_start), .STORE_DONE(STORE_DONE),
    .STOP_SIGNAL(b_stop), .ERR_SIGNAL(b_err), .ERR_CODE(b_err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] m,
                                     input logic aclr, input logic [1:0] dim,
                                     input logic [16:0] addr);
    return {addr, 1'b0, m, aclr, dim, op};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
  endtask

  initial begin
    RSTN = 1'b0; START_SIGNAL = 1'b0; INSTR = '0;
    MAC_DONE = 1'b0; FETCH_DONE = 1'b0; STORE_DONE = 1'b0;
    step(); step();

    // Reset values
    chk("rst_pc_incr", a_pc_incr, 0);
    chk("rst_rst_acc", a_rst_acc, 4'hF);
    chk("rst_rst_pc", a_rst_pc, 4'hF);
    chk("rst_rst_add", a_rst_add, 4'hF);
    chk("rst_addr_rst", a_addr_rst, 1);
    chk("rst_write_mat", a_write_mat, 0);
    chk("rst_address", a_address, 0);
    chk("rst_stop", a_stop, 0);
    chk("rst_err", a_err, 0);
    chk("rst_err_code", a_err_code, 0);
    chk("rst_rst_acc8", b_rst_acc, 8'hFF);

    RSTN = 1'b1;
    step();
    chk("idle_rst_pc_clr", a_rst_pc, 0);
    chk("idle_instr_done0", a_instr_done, 0);

    // Done input in an unrelated state
    MAC_DONE = 1'b1;
    #1 chk("idle_instr_done_mac", a_instr_done, 1);
    step();
    chk("idle_ignore_mac_pc", a_pc_incr, 0);
    chk("idle_ignore_mac_rstpc", a_rst_pc, 0);
    MAC_DONE = 1'b0;

    // Start -> FETCH, then LOADA mask 0101 addr 0xA0
    START_SIGNAL = 1'b1;
    INSTR = mk(3'd2, 8'h05, 1'b1, 2'd2, 17'h000A0);
    #1 chk("idle_instr_done_start", a_instr_done, 1);
    step();
    chk("fetch_pc_incr", a_pc_incr, 1);
    START_SIGNAL = 1'b0;
    step();
    chk("loada_pc_incr0", a_pc_incr, 0);
    chk("loada_rst_acc", a_rst_acc, 4'h5);
    chk("loada_dimen", a_dimen, 2);
    chk("loada_sel_b", a_mat_sel_b, 0);
    chk("loada_addr_start", a_addr_start, 1);
    for (int i = 1; i <= 5; i++) begin
      chk("loada_write_mat", a_write_mat, 4'h5);
      chk("loada_address", a_address, 17'h000A0);
      chk("loada_write_mat8", b_write_mat, 8'h05);
      if (i == 5) FETCH_DONE = 1'b1;
      step();
    end
    chk("loada_done_addr_rst", a_addr_rst, 1);
    chk("loada_done_rst_add", a_rst_add, 4'h5);
    chk("loada_done_rst_add8", b_rst_add, 8'h05);
    chk("loada_done_write_mat", a_write_mat, 0);
    chk("loada_done_addr_start", a_addr_start, 0);
    chk("loada_done_pc_incr", a_pc_incr, 1);
    FETCH_DONE = 1'b0;

    // MULTACC mask 1111, MAC_DONE on the 8th cycle
    INSTR = mk(3'd4, 8'h0F, 1'b0, 2'd1, 17'h0);
    step();
    chk("mac_rst_acc0", a_rst_acc, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("mac_ctrl", a_mac_ctrl, 4'hF);
      chk("mac_ctrl8", b_mac_ctrl, 8'h0F);
      if (i == 8) MAC_DONE = 1'b1;
      step();
    end
    chk("mac_done_ctrl", a_mac_ctrl, 0);
    chk("mac_done_rst_pc", a_rst_pc, 4'hF);
    chk("mac_done_rst_pc8", b_rst_pc, 8'h0F);
    chk("mac_done_pc_incr", a_pc_incr, 1);
    MAC_DONE = 1'b0;

    // STORE mask F0: illegal on 4 lanes, legal on 8 lanes
    INSTR = mk(3'd5, 8'hF0, 1'b0, 2'd3, 17'h1ABCD);
    step();
    chk("store4_err", a_err, 1);
    chk("store4_err_code", a_err_code, 2);
    chk("store4_stop", a_stop, 1);
    chk("store4_out_ready", a_out_ready, 0);
    chk("store8_address", b_address, 17'h1ABCD);
    chk("store8_err", b_err, 0);
    for (int i = 1; i <= 3; i++) begin
      chk("store8_out_ready", b_out_ready, 8'hF0);
      chk("store8_wraddr_start", b_wraddr_start, 1);
      chk("store8_addr_start", b_addr_start, 1);
      if (i == 3) STORE_DONE = 1'b1;
      step();
    end
    chk("store8_done_addr_rst", b_addr_rst, 1);
    chk("store8_done_out_ready", b_out_ready, 0);
    chk("store8_done_wraddr", b_wraddr_start, 0);
    chk("store4_err_held", a_err, 1);
    STORE_DONE = 1'b0;

    // Second STORE, reset asynchronously in the middle of it
    step();
    step();
    chk("store8_again", b_out_ready, 8'hF0);
    #2 RSTN = 1'b0;
    #1;
    chk("midrst_out_ready", b_out_ready, 0);
    chk("midrst_wraddr", b_wraddr_start, 0);
    chk("midrst_rst_acc", b_rst_acc, 8'hFF);
    chk("midrst_addr_rst", b_addr_rst, 1);
    chk("midrst_address", b_address, 0);
    chk("midrst_err4", a_err, 0);
    chk("midrst_code4", a_err_code, 0);
    step();

    // STOP opcode
    RSTN = 1'b1;
    START_SIGNAL = 1'b1;
    INSTR = mk(3'd6, 8'h00, 1'b0, 2'd0, 17'h0);
    step();
    START_SIGNAL = 1'b0;
    step();
    chk("stop_signal", a_stop, 1);
    chk("stop_no_err", a_err, 0);
    step();
    chk("stop_held", a_stop, 1);

    // Reserved opcode
    do_reset();
    START_SIGNAL = 1'b1;
    INSTR = mk(3'd7, 8'h01, 1'b0, 2'd0, 17'h0);
    step();
    START_SIGNAL = 1'b0;
    step();
    chk("op7_err", a_err, 1);
    chk("op7_code", a_err_code, 1);
    chk("op7_stop", a_stop, 1);
    INSTR = mk(3'd2, 8'h01, 1'b0, 2'd0, 17'h0);
    step();
    chk("op7_err_held", a_err, 1);
    chk("op7_no_write", a_write_mat, 0);

    // LOADB with empty mask
    do_reset();
    START_SIGNAL = 1'b1;
    INSTR = mk(3'd3, 8'h00, 1'b0, 2'd0, 17'h00055);
    step();
    START_SIGNAL = 1'b0;
    step();
    chk("loadb_m0_code", a_err_code, 2);
    chk("loadb_m0_err", a_err, 1);
    chk("loadb_m0_code8", b_err_code, 2);
    chk("loadb_m0_write", a_write_mat, 0);

`ifdef SIMD_CTRL_WDOG_EN
    // Watchdog: stall LOADA until timeout
    do_reset();
    START_SIGNAL = 1'b1;
    INSTR = mk(3'd2, 8'h01, 1'b0, 2'd0, 17'h00005);
    step();
    START_SIGNAL = 1'b0;
    step();
    cnt = 0;
    while (a_write_mat != 0 && cnt < 70000) begin
      cnt++;
      step();
    end
    chk("wdog_cycles", cnt, 65535);
    chk("wdog_code", a_err_code, 3);
    chk("wdog_err", a_err, 1);
    chk("wdog_addr_rst", a_addr_rst, 1);
    chk("wdog_stop", a_stop, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_ctrl_seq.md
Name: simd_ctrl_seq

Overview:
Parametrised control sequencer for the SIMD array, successor to the fixed 4-PE control FSM. It steps through IDLE/FETCH/LOADA/LOADB/MULTACC/STORE/STOP. PE count, address width and per-lane write masks are generalised. It adds explicit illegal-instruction detection with a sticky ERROR state. It sits between the instruction fetch unit, the PE array and the load/store data-fetch units.

Parameters:
NUM_PE, 4, number of PE lanes (1..8); width of all per-lane vectors.
ADDR_W, 17, memory address width; address field is INSTR[INSTR_W-1 -: ADDR_W].
INSTR_W, 32, instruction width; must satisfy INSTR_W >= 15+ADDR_W.
DIMEN_W, 2, matrix dimension code width.

Ports:
CLK  in  1  system clock, all state on rising edge.
RSTN  in  1  asynchronous active-low reset.
INSTR  in  INSTR_W  current instruction from fetch unit.
START_SIGNAL  in  1  GPIO start; level, sampled in IDLE.
PC_INCR  out  1  one-cycle pulse requesting next instruction.
INSTR_DONE  out  1  combinational: (IDLE & START_SIGNAL) | FETCH_DONE | MAC_DONE | STORE_DONE.
WRITE_MAT  out  NUM_PE  per-lane matrix write enable.
MAT_SEL_B  out  1  0 = write operand A, 1 = operand B.
MAC_CTRL  out  NUM_PE  per-lane MAC enable.
RST_ACC  out  NUM_PE  per-lane accumulator clear pulse.
RST_PC  out  NUM_PE  per-lane PE counter clear pulse.
RST_ADD  out  NUM_PE  per-lane address counter clear pulse.
OUT_READY  out  NUM_PE  per-lane result drive enable.
MAC_DONE  in  1  AND of all active-lane MAC done.
DIMEN  out  DIMEN_W  dimension code to fetch/PE.
ADDR_START  out  1  load/store address generator run.
ADDR_RST  out  1  address generator clear pulse.
ADDRESS  out  ADDR_W  base address, registered.
FETCH_DONE  in  1  load complete.
WRADDR_START  out  1  store address generator run.
STORE_DONE  in  1  store complete.
STOP_SIGNAL  out  1  program finished.
ERR_SIGNAL  out  1  sticky illegal-instruction flag.
ERR_CODE  out  2  1 = bad opcode, 2 = empty/out-of-range mask, 3 = timeout.

Behaviour:
- Instruction fields: OP=INSTR[2:0], DIM=INSTR[4:3], ACLR=INSTR[5], MASK=INSTR[13:6] (lane i = bit 6+i), ADDR=top ADDR_W bits.
- Opcodes: 0 IDLE, 1 FETCH, 2 LOADA, 3 LOADB, 4 MULTACC, 5 STORE, 6 STOP, 7 reserved (illegal).
- Reset values: all outputs 0, except RST_ACC, RST_PC and RST_ADD all-ones, and ADDR_RST=1. State = IDLE. ERR_CODE=0.
- Outputs are registered. Every pulse output defaults to 0 each cycle unless its state drives it. ADDRESS holds its value.
- IDLE: go to FETCH when START_SIGNAL=1.
- FETCH (1 cycle):
  - PC_INCR=1, DIMEN=DIM.
  - RST_ACC = ACLR ? MASK[NUM_PE-1:0] : 0.
  - Next state decoded from OP.
  - OP=7 -> ERROR, code 1.
  - OP in {2,3,4,5} with MASK[NUM_PE-1:0]==0 or any MASK bit >= NUM_PE set -> ERROR, code 2.
- LOADA/LOADB:
  - WRITE_MAT=MASK, MAT_SEL_B = (LOADB), ADDRESS=ADDR, DIMEN=DIM.
  - ADDR_START=~FETCH_DONE.
  - On FETCH_DONE: ADDR_RST=1, RST_ADD=MASK, go to FETCH.
- MULTACC:
  - MAC_CTRL = MASK while ~MAC_DONE.
  - On MAC_DONE: MAC_CTRL=0, RST_PC=MASK, go to FETCH.
- STORE:
  - OUT_READY=MASK, WRADDR_START=1, ADDRESS=ADDR.
  - ADDR_START=~STORE_DONE.
  - On STORE_DONE: ADDR_RST=1, go to FETCH.
- STOP: STOP_SIGNAL=1 held; terminal until reset.
- ERROR:
  - ERR_SIGNAL=1 held; all lane enables 0. Terminal until reset.
  - STOP_SIGNAL is also asserted, so the host sees completion.
- A done input that arrives in an unrelated state is ignored for state; INSTR_DONE still reflects it.
- Reset mid-operation: async clear to reset values within the same cycle, with no completion pulses.
- MASK bits above NUM_PE are never driven onto lanes.

Optional Feature:
SIMD_CTRL_WDOG_EN: adds a 16-bit watchdog counter.
- Clears on every state entry and increments each cycle in LOADA/LOADB/MULTACC/STORE.
- On reaching 16'hFFFF: go to ERROR with ERR_CODE=3, ADDR_RST=1 and all lane enables dropped.
- Without the macro: no counter; those states wait indefinitely; ERR_CODE=3 is never produced.

Test Plan:
- Reset then START_SIGNAL=1 -> IDLE->FETCH in 1 cycle; PC_INCR pulses once; reset values checked before START.
- NUM_PE=4, LOADA with MASK=4'b0101, ADDR=17'h00A0, FETCH_DONE after 5 cycles -> WRITE_MAT=0101 and ADDRESS=0x00A0 for 5 cycles; then ADDR_RST=1 and RST_ADD=0101 for 1 cycle; return to FETCH.
- MULTACC MASK=1111 with MAC_DONE at cycle 8 -> MAC_CTRL=1111 for cycles 1-8, then 0; RST_PC=1111 for 1 cycle.
- OP=7 -> ERR_SIGNAL=1, ERR_CODE=1, STOP_SIGNAL=1. LOADB with MASK=0 -> ERR_CODE=2.
- NUM_PE=8, STORE MASK=8'hF0 with STORE_DONE after 3 cycles -> OUT_READY=F0 and WRADDR_START=1 for 3 cycles; RSTN low mid-STORE -> immediate reset values.
- With SIMD_CTRL_WDOG_EN, hold FETCH_DONE=0 in LOADA -> ERROR with ERR_CODE=3 after 65535 cycles.
